// File: rtl/game_ctrl.sv
// game_ctrl: game-state sequencer with per-frame collision, pass scoring and hiscore tracking
module game_ctrl #(
    parameter int N          = 10,
    parameter int BIRD_SIZE  = 15,
    parameter int PIPE_W     = 40,
    parameter int SCREEN_H   = 480,
    parameter int HIT_FRAMES = 30,
    parameter int SW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          frame_tick,
    input  logic [N-1:0]  x0,
    input  logic [N-1:0]  x1,
    input  logic [N-1:0]  y0,
    input  logic [N-1:0]  y1,
    input  logic [N-1:0]  pipe_x,
    input  logic [N-1:0]  gap_top,
    input  logic [N-1:0]  gap_bottom,
    output logic          bird_rst,
    output logic          freeze,
    output logic          playing,
    output logic          game_over,
    output logic          point,
    output logic [SW-1:0] score,
    output logic [SW-1:0] hiscore
);
    localparam int CW = $clog2(HIT_FRAMES + 1);
    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
    state_t state, state_n;
    logic start_q, passed;
    logic [N-1:0] prev_pipe_x;
    logic [CW-1:0] cnt;
    logic unused_x1;
    assign unused_x1 = ^x1;
    // widened by one bit so right edges near the top of the coordinate range never wrap
    logic [N:0] bird_r, pipe_r, x0_w, px_w;
    assign x0_w   = {1'b0, x0};
    assign px_w   = {1'b0, pipe_x};
    assign bird_r = x0_w + (N+1)'(BIRD_SIZE);
    assign pipe_r = px_w + (N+1)'(PIPE_W);
    logic start_rise, border, pipe_hit, coll, pass, wrap, hit_done;
    assign start_rise = start & ~start_q;
    assign border     = (y1 == '0) || ({1'b0, y0} >= (N+1)'(SCREEN_H));
    assign pipe_hit   = (bird_r > px_w) && (x0_w < pipe_r) && ((y1 < gap_top) || (y0 > gap_bottom));
    assign coll       = border | pipe_hit;
    assign pass       = !coll && !passed && (pipe_r <= x0_w);
    assign wrap       = pipe_x > prev_pipe_x;
    assign hit_done   = cnt == CW'(HIT_FRAMES - 1);
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n   = state;
        bird_rst  = state == IDLE;
        freeze    = state != PLAY;
        playing   = state == PLAY;
        game_over = state == OVER;
        case (state)
            IDLE: state_n = start_rise ? PLAY : IDLE;
            PLAY: state_n = (frame_tick && coll) ? HIT : PLAY;
            HIT:  state_n = (frame_tick && hit_done) ? OVER : HIT;
            OVER: state_n = start_rise ? IDLE : OVER;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= 1'b0;
            point       <= 1'b0;
            passed      <= 1'b0;
            score       <= '0;
            hiscore     <= '0;
            cnt         <= '0;
            prev_pipe_x <= '0;
        end else begin
            start_q <= start;
            point   <= 1'b0;
            case (state)
                IDLE: if (start_rise) begin
                    score       <= '0;
                    passed      <= 1'b0;
                    prev_pipe_x <= pipe_x;
                end
                PLAY: if (frame_tick) begin
                    prev_pipe_x <= pipe_x;
                    passed      <= wrap ? 1'b0 : (pass | passed);
                    if (coll) begin
                        cnt <= '0;
                        if (score > hiscore) hiscore <= score;
                    end
                    // saturating increment; the point pulse still fires at the ceiling
                    if (pass) begin
                        score <= score + SW'(score != '1);
                        point <= 1'b1;
                    end
                end
                HIT: if (frame_tick) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl, plus a 2-bit score instance for saturation
module tb_game_ctrl;
    logic clk = 0, reset = 1, start = 0, frame_tick = 0;
    logic [9:0] x0 = 160, y0 = 247, y1 = 233, pipe_x = 200, gap_top = 200, gap_bottom = 300;
    logic bird_rst, freeze, playing, game_over, point;
    logic [7:0] score, hiscore;
    logic b2, f2, p2, g2, pt2;
    logic [1:0] s2, h2;
    int checks = 0, errors = 0, pc2 = 0;
    localparam logic [3:0] S_IDLE = 4'b1100, S_PLAY = 4'b0010, S_HIT = 4'b0100, S_OVER = 4'b0101;

    game_ctrl dut (.clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .x0(x0), .x1(x0), .y0(y0), .y1(y1), .pipe_x(pipe_x), .gap_top(gap_top),
        .gap_bottom(gap_bottom), .bird_rst(bird_rst), .freeze(freeze), .playing(playing),
        .game_over(game_over), .point(point), .score(score), .hiscore(hiscore));

    game_ctrl #(.SW(2)) dut2 (.clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .x0(x0), .x1(x0), .y0(y0), .y1(y1), .pipe_x(pipe_x), .gap_top(gap_top),
        .gap_bottom(gap_bottom), .bird_rst(b2), .freeze(f2), .playing(p2),
        .game_over(g2), .point(pt2), .score(s2), .hiscore(h2));

    always #5 clk = ~clk;
    always @(negedge clk) if (pt2 === 1'b1) pc2++;

    typedef struct {
        string      tag;
        logic [3:0] st;
        int         sc;
        int         hi;
        logic       pt;
    } exp_t;
    exp_t q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (q.size() == 0) chk("sb_underflow", 0, 1);
        else begin
            e = q.pop_front();
            chk({e.tag, "_state"}, 32'({bird_rst, freeze, playing, game_over}), 32'(e.st));
            chk({e.tag, "_score"}, 32'(score), e.sc);
            chk({e.tag, "_hiscore"}, 32'(hiscore), e.hi);
            chk({e.tag, "_point"}, 32'(point), 32'(e.pt));
        end
    endtask

    task automatic step(bit tk, logic [9:0] px, bit sv, logic [3:0] st, int sc, int hi, bit pt, string tag);
        @(negedge clk);
        pipe_x = px; frame_tick = tk; start = sv;
        q.push_back('{tag, st, sc, hi, pt});
        @(negedge clk);
        frame_tick = 0;
        check_pop();
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1; start = 0; frame_tick = 0;
        q.push_back('{tag, S_IDLE, 0, 0, 1'b0});
        @(negedge clk);
        reset = 0;
        check_pop();
    endtask

    initial begin
        do_reset("reset");
        step(0, 200, 1, S_PLAY, 0, 0, 0, "start");
        for (int px = 200; px >= 110; px -= 10)
            step(1, 10'(px), 1, S_PLAY, px <= 120 ? 1 : 0, 0, px == 120, "pass1");
        y0 = 480; y1 = 465;
        step(0, 110, 1, S_PLAY, 1, 0, 0, "notick");
        y0 = 247; y1 = 233;
        step(1, 600, 1, S_PLAY, 1, 0, 0, "wrap");
        for (int px = 200; px >= 110; px -= 10)
            step(1, 10'(px), 1, S_PLAY, px <= 120 ? 2 : 1, 0, px == 120, "pass2");
        for (int i = 0; i < 3; i++) step(1, 110, 1, S_PLAY, 2, 0, 0, "hold");
        y1 = 190; y0 = 204;
        step(1, 150, 1, S_HIT, 2, 2, 0, "pipe_hit");
        step(0, 150, 1, S_HIT, 2, 2, 0, "hit_notick");
        for (int i = 1; i <= 30; i++)
            step(1, 150, 1, i == 30 ? S_OVER : S_HIT, 2, 2, 0, "hit_count");
        step(0, 150, 1, S_OVER, 2, 2, 0, "over_held");
        step(0, 150, 1, S_OVER, 2, 2, 0, "over_held2");
        step(0, 150, 0, S_OVER, 2, 2, 0, "over_rel");
        step(0, 150, 1, S_IDLE, 2, 2, 0, "to_idle");
        step(0, 150, 0, S_IDLE, 2, 2, 0, "idle_rel");
        y0 = 479; y1 = 464;
        step(0, 600, 1, S_PLAY, 0, 2, 0, "replay");
        step(1, 600, 1, S_PLAY, 0, 2, 0, "y0_479");
        y0 = 480; y1 = 465;
        step(1, 590, 1, S_HIT, 0, 2, 0, "y0_480");
        do_reset("reset_hit");
        y0 = 14; y1 = 0;
        step(0, 600, 1, S_PLAY, 0, 0, 0, "start2");
        step(1, 110, 1, S_HIT, 0, 0, 0, "y1_0_with_pass");
        y0 = 247; y1 = 233;
        do_reset("reset3");
        pc2 = 0;
        step(0, 100, 1, S_PLAY, 0, 0, 0, "start3");
        step(1, 110, 1, S_PLAY, 1, 0, 1, "wrap_pass");
        chk("sat_s2_a", 32'(s2), 1);
        step(1, 105, 1, S_PLAY, 2, 0, 1, "after_wrap_pass");
        chk("sat_s2_b", 32'(s2), 2);
        step(1, 100, 1, S_PLAY, 2, 0, 0, "passed_held");
        step(1, 600, 1, S_PLAY, 2, 0, 0, "sat_wrap1");
        step(1, 120, 1, S_PLAY, 3, 0, 1, "sat_pass3");
        chk("sat_s2_c", 32'(s2), 3);
        step(1, 600, 1, S_PLAY, 3, 0, 0, "sat_wrap2");
        step(1, 120, 1, S_PLAY, 4, 0, 1, "sat_pass4");
        chk("sat_s2_d", 32'(s2), 3);
        chk("sat_pt2", 32'(pt2), 1);
        step(1, 110, 1, S_PLAY, 4, 0, 0, "sat_tail");
        chk("sat_pulses", pc2, 4);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-state controller at the consuming end of the bird position interface. It reads the bird bounding box (x0, y0, x1, y1) and the current pipe geometry once per video frame, detects collisions with pipes and screen borders, counts passed pipes, and sequences the game through idle, play, hit-flash and game-over states. Its outputs drive the bird block's reset and freeze and feed the score display.

## Interface
- N, 10, coordinate width in bits
- BIRD_SIZE, 15, bird box width in pixels; horizontal span is x0 .. x0+BIRD_SIZE-1
- PIPE_W, 40, pipe width in pixels
- SCREEN_H, 480, screen height; bottom border row
- HIT_FRAMES, 30, frames spent in HIT before OVER (>=1)
- SW, 8, score width in bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain
- start  in  1  player start/flap key, level
- frame_tick  in  1  one-cycle pulse per video frame
- x0, x1  in  N  bird left x (equal values; x0 used)
- y0  in  N  bird bottom y (larger value)
- y1  in  N  bird top y
- pipe_x  in  N  pipe left x; decreases each frame, wraps to a larger value for a new pipe
- gap_top, gap_bottom  in  N  pipe opening rows, gap_top < gap_bottom
- bird_rst  out  1  holds bird block in reset
- freeze  out  1  bird and pipes must stop moving
- playing, game_over  out  1  state flags
- point  out  1  one-cycle pulse on each score increment
- score  out  SW  current score
- hiscore  out  SW  best score since reset

## Operation
- States: IDLE, PLAY, HIT, OVER.
- start_rise = start & ~start_q; start_q is a register cleared by reset.
- IDLE: bird_rst=1, freeze=1. On start_rise -> PLAY; score cleared to 0, passed flag cleared, prev_pipe_x loaded with pipe_x.
- PLAY: bird_rst=0, freeze=0, playing=1. All evaluation happens only on cycles with frame_tick=1.
- Collision on a tick: y1 == 0, or y0 >= SCREEN_H, or pipe hit. Pipe hit requires horizontal overlap, x0+BIRD_SIZE > pipe_x and x0 < pipe_x+PIPE_W, together with y1 < gap_top or y0 > gap_bottom.
- All sums are computed at N+1 bits. There is no wrap in the comparisons.
- On collision: go to HIT and clear the frame counter. If score > hiscore, hiscore <= score. There is no score increment on that tick.
- Pass rule: if there is no collision, passed=0 and pipe_x+PIPE_W <= x0, then score <= score+1, point=1 for that cycle and passed <= 1.
  - score saturates at 2^SW-1. point still pulses at saturation.
- Wrap rule: on a tick where pipe_x > prev_pipe_x, passed <= 0. prev_pipe_x <= pipe_x on every PLAY tick.
- HIT: freeze=1, bird_rst=0. The frame counter increments on each tick. When the count reaches HIT_FRAMES, go to OVER.
- OVER: freeze=1, game_over=1, and score is held. On start_rise -> IDLE.
- start has no effect in PLAY or HIT.
- Reset, including mid-game: state=IDLE, score=0, hiscore=0, passed=0, counter=0, start_q=0.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Reset values: bird_rst=1, freeze=1, playing=0, game_over=0, point=0, score=0, hiscore=0.
- IDLE->PLAY: state changes and bird_rst falls on the cycle after start_rise is seen.
- Collision latency: state is HIT on the cycle after the colliding frame_tick. hiscore updates on the same edge.
- HIT lasts exactly HIT_FRAMES frame_ticks. The OVER transition happens on the edge of the HIT_FRAMES-th tick.
- point is high on the cycle after the qualifying tick, together with the new score value.
- Inputs are sampled only when frame_tick=1 in PLAY/HIT. Between ticks, input changes are ignored.
- Simultaneous events:
  - collision and pass on the same tick: collision wins and score is unchanged.
  - wrap and pass on the same tick: the pass counts first, then passed is cleared.
  - reset with anything: reset wins.

## Test plan
- Reset, then start pulse -> bird_rst 1→0 and playing=1 one cycle later; score=0, hiscore=0.
- PLAY with x0=160, bird at y1=233/y0=247, gap 200..300, and pipe_x stepping 200→110 one tick at a time -> no HIT. Exactly one point pulse at pipe_x=120; score=1.
- Then pipe_x wraps to 600 and is stepped down to 110 again -> second point; score=2. Holding pipe_x at 110 for more ticks gives no extra points.
- Pipe at pipe_x=150 with y1=190 (<gap_top 200) -> HIT after the tick; hiscore=2; after 30 ticks OVER, game_over=1.
- OVER with start held from before, no new rise -> stays OVER. Release then press -> IDLE; press again -> PLAY with score=0 and hiscore=2.
- Border checks: y0=480 on a tick -> HIT, and y1=0 -> HIT. Assert reset during HIT -> IDLE, hiscore=0, bird_rst=1.
- SW=2 build: force 4 passes -> score sticks at 3 and point pulses 4 times.
